// File: rtl/store_path_ctrl_if.sv
// Store path bundle: datapath store request/response plus the data RAM port.
// The "slave" modport is the store controller; the "master" modport is
// everything around it (datapath register read side and the RAM itself).
interface store_path_ctrl_if #(
    parameter int ADDR_W = 32
);
    logic              str_req;
    logic [ADDR_W-1:0] str_addr;
    logic [31:0]       str_data;
    logic [1:0]        str_size;
    logic              str_busy;
    logic              str_done;
    logic              str_err;
    logic              ram_en;
    logic              ram_we;
    logic [ADDR_W-3:0] ram_addr;
    logic [31:0]       ram_wdata;
    logic [31:0]       ram_rdata;
    logic              ram_ready;

    modport master (
        output str_req, str_addr, str_data, str_size, ram_rdata, ram_ready,
        input  str_busy, str_done, str_err, ram_en, ram_we, ram_addr, ram_wdata
    );

    modport slave (
        input  str_req, str_addr, str_data, str_size, ram_rdata, ram_ready,
        output str_busy, str_done, str_err, ram_en, ram_we, ram_addr, ram_wdata
    );
endinterface

// File: rtl/store_path_ctrl.sv
// Store path controller: writes register data to the data RAM on a store
// request. Word stores are a single write; byte and halfword stores are a
// read-modify-write because the RAM port has no byte enables.
// All outputs are registered and computed from the next FSM state.
// Optional feature: define STR_TIMEOUT_EN to abort a RAM access that has
// waited TIMEOUT_CYC cycles for ram_ready (reported through str_err).
module store_path_ctrl #(
    parameter int ADDR_W      = 32,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic clk,
    input  logic rst_n,
    store_path_ctrl_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE,
        RD,
        WR,
        DONE
    } stateT;

    stateT       state;
    stateT       nextState;
    logic [1:0]  laneQ;
    logic [31:0] dataQ;
    logic [1:0]  sizeQ;
    logic        errQ;
    logic        errNext;
    logic        reqBad;
    logic        timeoutHit;
    logic [31:0] mergedWord;

    // Illegal size or an address not aligned to the access size
    assign reqBad = (bus.str_size == 2'b11) ||
                    ((bus.str_size == 2'b01) && bus.str_addr[0]) ||
                    ((bus.str_size == 2'b10) && (bus.str_addr[1:0] != 2'b00));

`ifdef STR_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

    logic [CNT_W-1:0] waitCnt;

    // Count cycles spent waiting for ram_ready; restart on every state change
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            waitCnt <= '0;
        end else if (nextState != state) begin
            waitCnt <= '0;
        end else if (((state == RD) || (state == WR)) && !bus.ram_ready) begin
            waitCnt <= waitCnt + 1'b1;
        end
    end

    assign timeoutHit = ((state == RD) || (state == WR)) && !bus.ram_ready &&
                        ((32'(waitCnt) + 32'd1) == 32'(TIMEOUT_CYC));
`else
    assign timeoutHit = 1'b0;
`endif

    // Little-endian merge of the latched store data into the word read back
    always_comb begin
        mergedWord = bus.ram_rdata;
        if (sizeQ == 2'b00) begin
            mergedWord[8*laneQ +: 8] = dataQ[7:0];
        end else if (sizeQ == 2'b01) begin
            mergedWord[16*laneQ[1] +: 16] = dataQ[15:0];
        end
    end

    // Next-state and error decode
    always_comb begin
        nextState = state;
        errNext   = errQ;
        case (state)
            IDLE: begin
                if (bus.str_req) begin
                    errNext = reqBad;
                    if (reqBad) begin
                        nextState = DONE;
                    end else if (bus.str_size == 2'b10) begin
                        nextState = WR;
                    end else begin
                        nextState = RD;
                    end
                end
            end
            RD: begin
                if (bus.ram_ready) begin
                    nextState = WR;
                end else if (timeoutHit) begin
                    nextState = DONE;
                    errNext   = 1'b1;
                end
            end
            WR: begin
                if (bus.ram_ready) begin
                    nextState = DONE;
                end else if (timeoutHit) begin
                    nextState = DONE;
                    errNext   = 1'b1;
                end
            end
            DONE: begin
                nextState = IDLE;
            end
            default: begin
                nextState = IDLE;
            end
        endcase
    end

    // State, request latches and registered outputs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state         <= IDLE;
            laneQ         <= 2'b00;
            dataQ         <= 32'h0;
            sizeQ         <= 2'b00;
            errQ          <= 1'b0;
            bus.str_busy  <= 1'b0;
            bus.str_done  <= 1'b0;
            bus.str_err   <= 1'b0;
            bus.ram_en    <= 1'b0;
            bus.ram_we    <= 1'b0;
            bus.ram_addr  <= '0;
            bus.ram_wdata <= 32'h0;
        end else begin
            state <= nextState;
            errQ  <= errNext;
            if ((state == IDLE) && bus.str_req) begin
                laneQ        <= bus.str_addr[1:0];
                dataQ        <= bus.str_data;
                sizeQ        <= bus.str_size;
                bus.ram_addr <= bus.str_addr[ADDR_W-1:2];
            end
            if ((state == IDLE) && bus.str_req && (bus.str_size == 2'b10)) begin
                bus.ram_wdata <= bus.str_data;
            end else if ((state == RD) && bus.ram_ready) begin
                bus.ram_wdata <= mergedWord;
            end
            bus.str_busy <= (nextState != IDLE);
            bus.ram_en   <= (nextState == RD) || (nextState == WR);
            bus.ram_we   <= (nextState == WR);
            bus.str_done <= (nextState == DONE);
            bus.str_err  <= (nextState == DONE) && errNext;
        end
    end

endmodule
